// File: rtl/alu_issue_ctrl.sv
// Issue and write-back stage around a combinational ALU.
// A 4-entry register file supplies operands. Immediate loads retire in one
// cycle. An ALU op is captured into registered ALU inputs, spends one EXEC
// cycle while the ALU settles, and then writes its result back.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_load,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [2:0]       in_opcode,
  input  logic             in_cin,
  input  logic [1:0]       in_ra,
  input  logic [1:0]       in_rb,
  input  logic [1:0]       in_rd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opcode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             zero_flag,
  output logic             done,
  output logic [CNT_W-1:0] retired,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StExec = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] rf_q [4];
  logic [1:0]       rd_q, rd_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Single register-file write port; loads and write-backs never coincide
  // because EXEC blocks new handshakes.
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;

  logic accept;

  // Handshake is only possible while idle.
  always_comb begin
    in_ready = (state_q == StIdle);
    accept   = in_valid & in_ready;
  end

  // Next-state logic: issue, load retire and ALU write-back.
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    alu_cin_d = alu_cin_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    retired_d = retired_q;
    wr_en     = 1'b0;
    wr_addr   = in_rd;
    wr_data   = in_imm;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_load) begin
            wr_en     = 1'b1;
            wr_addr   = in_rd;
            wr_data   = in_imm;
            done_d    = 1'b1;
            retired_d = retired_q + CNT_W'(1);
          end else begin
            // Operands are read from the pre-write file contents.
            alu_a_d   = rf_q[in_ra];
            alu_b_d   = rf_q[in_rb];
            alu_op_d  = in_opcode;
            alu_cin_d = in_cin;
            rd_d      = in_rd;
            state_d   = StExec;
          end
        end
      end
      StExec: begin
        wr_en     = 1'b1;
        wr_addr   = rd_q;
        wr_data   = alu_result;
        zero_d    = alu_zero;
        done_d    = 1'b1;
        retired_d = retired_q + CNT_W'(1);
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control and ALU-input registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rd_q      <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_cin_q <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      alu_cin_q <= alu_cin_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      retired_q <= retired_d;
    end
  end

  // Register file storage; reset clears all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wr_en) begin
      rf_q[wr_addr] <= wr_data;
    end
  end

  // Output mapping and combinational debug read.
  always_comb begin
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    alu_opcode = alu_op_q;
    alu_cin    = alu_cin_q;
    zero_flag  = zero_q;
    done       = done_q;
    retired    = retired_q;
    dbg_data   = rf_q[dbg_addr];
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed vectors, hand-written
// multi-cycle sequences and random instructions checked against a model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_load, in_cin;
  logic [7:0] in_imm;
  logic [2:0] in_opcode;
  logic [1:0] in_ra, in_rb, in_rd, dbg_addr;

  logic        in_ready, alu_cin, zero_flag, done, alu_zero;
  logic [7:0]  alu_a, alu_b, alu_result, dbg_data;
  logic [2:0]  alu_opcode;
  logic [15:0] retired;

  // Second instance with a 2-bit counter for the wrap check.
  logic       w_ready, w_alu_cin, w_zero_flag, w_done, w_alu_zero;
  logic [7:0] w_alu_a, w_alu_b, w_alu_result, w_dbg_data;
  logic [2:0] w_alu_opcode;
  logic [1:0] w_retired;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Bench-side ALU: 0 pass A, 1 add, 2 sub, 3 and, 4 or, 5 xor, 6 shl, 7 not A.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op, input logic cin);
    case (op)
      3'd0: return a;
      3'd1: return 8'(a + b + {7'b0, cin});
      3'd2: return 8'(a + ~b + {7'b0, cin});
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return {a[6:0], cin};
      default: return ~a;
    endcase
  endfunction

  assign alu_result   = alu_f(alu_a, alu_b, alu_opcode, alu_cin);
  assign alu_zero     = (alu_result == 8'h00);
  assign w_alu_result = alu_f(w_alu_a, w_alu_b, w_alu_opcode, w_alu_cin);
  assign w_alu_zero   = (w_alu_result == 8'h00);

  alu_issue_ctrl #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_imm(in_imm), .in_opcode(in_opcode), .in_cin(in_cin),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_zero(alu_zero), .zero_flag(zero_flag),
    .done(done), .retired(retired), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu_issue_ctrl #(.WIDTH(8), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_ready),
    .in_load(in_load), .in_imm(in_imm), .in_opcode(in_opcode), .in_cin(in_cin),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd),
    .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_opcode(w_alu_opcode), .alu_cin(w_alu_cin),
    .alu_result(w_alu_result), .alu_zero(w_alu_zero), .zero_flag(w_zero_flag),
    .done(w_done), .retired(w_retired), .dbg_addr(dbg_addr), .dbg_data(w_dbg_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction, wait (bounded) for acceptance, and run it to
  // retirement. For ALU ops the registered ALU inputs are checked in EXEC.
  task automatic do_instr(input logic load, input logic [7:0] imm, input logic [2:0] op,
                          input logic cin, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [1:0] rd, input logic [7:0] exp_a,
                          input logic [7:0] exp_b);
    in_load = load; in_imm = imm; in_opcode = op; in_cin = cin;
    in_ra = ra; in_rb = rb; in_rd = rd; in_valid = 1'b1;
    for (int k = 0; k < 10 && !in_ready; k++) step();
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    if (!load) begin
      chk("exec_ready", 32'(in_ready), 32'(0));
      chk("exec_alu_a", 32'(alu_a), 32'(exp_a));
      chk("exec_alu_b", 32'(alu_b), 32'(exp_b));
      chk("exec_alu_op", 32'(alu_opcode), 32'(op));
      chk("exec_alu_cin", 32'(alu_cin), 32'(cin));
      chk("exec_done", 32'(done), 32'(0));
      step();
    end
  endtask

  typedef struct {
    logic       load;
    logic [7:0] imm;
    logic [2:0] op;
    logic       cin;
    logic [1:0] ra, rb, rd;
    logic [7:0] exp_a, exp_b, exp_val;
    logic       exp_z;
  } vec_t;

  function automatic vec_t mk(input logic load, input logic [7:0] imm, input logic [2:0] op,
                              input logic cin, input logic [1:0] ra, input logic [1:0] rb,
                              input logic [1:0] rd, input logic [7:0] ea, input logic [7:0] eb,
                              input logic [7:0] ev, input logic ez);
    vec_t v;
    v.load = load; v.imm = imm; v.op = op; v.cin = cin; v.ra = ra; v.rb = rb; v.rd = rd;
    v.exp_a = ea; v.exp_b = eb; v.exp_val = ev; v.exp_z = ez;
    return v;
  endfunction

  vec_t vecs[11];

  logic [7:0] m_rf[4];
  logic       m_z;
  int         m_ret;

  initial begin
    vecs[0]  = mk(1'b1, 8'd10, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'd10, 1'b0);
    vecs[1]  = mk(1'b1, 8'd3,  3'd0, 1'b0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'd3,  1'b0);
    vecs[2]  = mk(1'b0, 8'd0,  3'd1, 1'b0, 2'd0, 2'd1, 2'd2, 8'd10, 8'd3,  8'd13, 1'b0);
    vecs[3]  = mk(1'b1, 8'd5,  3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'd5,  1'b0);
    vecs[4]  = mk(1'b1, 8'd5,  3'd0, 1'b0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'd5,  1'b0);
    vecs[5]  = mk(1'b0, 8'd0,  3'd2, 1'b1, 2'd0, 2'd1, 2'd3, 8'd5,  8'd5,  8'd0,  1'b1);
    vecs[6]  = mk(1'b1, 8'hAA, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h00, 8'hAA, 1'b1);
    vecs[7]  = mk(1'b1, 8'h55, 3'd0, 1'b0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'h55, 1'b1);
    vecs[8]  = mk(1'b0, 8'd0,  3'd3, 1'b0, 2'd0, 2'd1, 2'd2, 8'hAA, 8'h55, 8'h00, 1'b1);
    vecs[9]  = mk(1'b0, 8'd0,  3'd4, 1'b0, 2'd0, 2'd1, 2'd2, 8'hAA, 8'h55, 8'hFF, 1'b0);
    vecs[10] = mk(1'b0, 8'd0,  3'd7, 1'b0, 2'd1, 2'd0, 2'd2, 8'h55, 8'hAA, 8'hAA, 1'b0);

    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_imm = '0; in_opcode = '0;
    in_cin = 1'b0; in_ra = '0; in_rb = '0; in_rd = '0; dbg_addr = '0;
    step(); step();
    rst = 1'b0;

    // Reset state.
    chk("rst_ready", 32'(in_ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_retired", 32'(retired), 32'(0));
    chk("rst_zero", 32'(zero_flag), 32'(0));
    chk("rst_alu_a", 32'(alu_a), 32'(0));
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk("rst_rf", 32'(dbg_data), 32'(0));
    end

    // Directed vectors.
    for (int i = 0; i < 11; i++) begin
      do_instr(vecs[i].load, vecs[i].imm, vecs[i].op, vecs[i].cin, vecs[i].ra, vecs[i].rb,
               vecs[i].rd, vecs[i].exp_a, vecs[i].exp_b);
      dbg_addr = vecs[i].rd;
      #1;
      chk("vec_rd_val", 32'(dbg_data), 32'(vecs[i].exp_val));
      chk("vec_zero", 32'(zero_flag), 32'(vecs[i].exp_z));
      chk("vec_done", 32'(done), 32'(1));
      chk("vec_retired", 32'(retired), 32'(i + 1));
    end
    step();
    chk("idle_done_low", 32'(done), 32'(0));
    chk("idle_alu_a_hold", 32'(alu_a), 32'(8'h55));
    chk("idle_alu_b_hold", 32'(alu_b), 32'(8'hAA));

    // Back-to-back with in_valid held across EXEC; rf = {AA,55,AA,00}.
    dbg_addr = 2'd3;
    in_load = 1'b0; in_opcode = 3'd1; in_cin = 1'b0; in_ra = 2'd0; in_rb = 2'd1;
    in_rd = 2'd3; in_valid = 1'b1;
    step();
    chk("hs_exec_ready", 32'(in_ready), 32'(0));
    in_opcode = 3'd5; in_ra = 2'd3; in_rb = 2'd0; in_rd = 2'd0;
    step();
    chk("hs_retire_done", 32'(done), 32'(1));
    chk("hs_retire_ready", 32'(in_ready), 32'(1));
    chk("hs_retire_cnt", 32'(retired), 32'(12));
    chk("hs_r3", 32'(dbg_data), 32'(8'hFF));
    step();
    chk("hs2_ready", 32'(in_ready), 32'(0));
    chk("hs2_done", 32'(done), 32'(0));
    chk("hs2_dep_a", 32'(alu_a), 32'(8'hFF));
    chk("hs2_b", 32'(alu_b), 32'(8'hAA));
    chk("hs2_cnt", 32'(retired), 32'(12));
    in_valid = 1'b0;
    step();
    dbg_addr = 2'd0;
    #1;
    chk("hs2_done_pulse", 32'(done), 32'(1));
    chk("hs2_cnt2", 32'(retired), 32'(13));
    chk("hs2_r0", 32'(dbg_data), 32'(8'h55));
    chk("hs2_zero", 32'(zero_flag), 32'(0));

    // Reset during EXEC.
    do_instr(1'b1, 8'd7, 3'd0, 1'b0, 2'd0, 2'd0, 2'd1, 8'h00, 8'h00);
    dbg_addr = 2'd1;
    in_load = 1'b0; in_opcode = 3'd1; in_cin = 1'b1; in_ra = 2'd1; in_rb = 2'd1;
    in_rd = 2'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("rx_in_exec", 32'(in_ready), 32'(0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rx_r1", 32'(dbg_data), 32'(0));
    chk("rx_done", 32'(done), 32'(0));
    chk("rx_retired", 32'(retired), 32'(0));
    chk("rx_ready", 32'(in_ready), 32'(1));
    step();
    chk("rx_done_later", 32'(done), 32'(0));
    chk("rx_r1_later", 32'(dbg_data), 32'(0));

    // Counter wrap: five back-to-back loads, one per cycle.
    for (int i = 0; i < 5; i++) begin
      in_load = 1'b1; in_imm = 8'(i + 1); in_rd = 2'(i); in_valid = 1'b1;
      step();
      chk("wrap_cnt", 32'(w_retired), 32'((i + 1) % 4));
      chk("wrap_cnt16", 32'(retired), 32'(i + 1));
      chk("wrap_done", 32'(w_done), 32'(1));
    end
    in_valid = 1'b0;

    // Random instructions against the model, starting from reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_z = 1'b0;
    m_ret = 0;
    for (int n = 0; n < 150; n++) begin
      logic       ld, c;
      logic [7:0] im, res;
      logic [2:0] op;
      logic [1:0] ra, rb, rd;
      ld = ($urandom_range(0, 2) == 0);
      im = 8'($urandom);
      op = 3'($urandom);
      c  = 1'($urandom);
      ra = 2'($urandom);
      rb = 2'($urandom);
      rd = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk("rnd_gap_done", 32'(done), 32'(0));
      end
      do_instr(ld, im, op, c, ra, rb, rd, m_rf[ra], m_rf[rb]);
      if (ld) begin
        m_rf[rd] = im;
      end else begin
        res = alu_f(m_rf[ra], m_rf[rb], op, c);
        m_rf[rd] = res;
        m_z = (res == 8'h00);
      end
      m_ret++;
      dbg_addr = 2'($urandom);
      #1;
      chk("rnd_rf", 32'(dbg_data), 32'(m_rf[dbg_addr]));
      chk("rnd_zero", 32'(zero_flag), 32'(m_z));
      chk("rnd_done", 32'(done), 32'(1));
      chk("rnd_retired", 32'(retired), 32'(m_ret));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
